multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS core, replacing per-instruction single-cycle control with a state machine.
- Decodes the 6-bit opcode set R-type/lw/sw/beq/bne/bgtz/addi.
- Each cycle, drives shared-datapath selects and enables (one ALU, one unified memory port), waits on a memory ready handshake, and guards every memory access with a timeout.

Parameters:
- OPCODE_W, 6: opcode width.
- TIMEOUT_W, 4: width of the memory-wait counter.
- MEM_TIMEOUT, 12: maximum wait cycles for mem_ready before abort; legal range 1 to 2^TIMEOUT_W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  allow a new instruction fetch; sampled only in FETCH before a request is issued.
- opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- mem_req  out  1  memory access request; held high until mem_ready or timeout.
- mem_read  out  1  request is a read.
- mem_write  out  1  request is a write.
- i_or_d  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  unconditional PC update.
- branch_eq / branch_ne / branch_gtz  out  1 each  conditional PC-write qualifiers for the datapath.
- pc_source  out  1  PC source: 0=ALU result, 1=ALUOut (branch target).
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  3  ALU operation: 000 add, 001 compare/sub (branch), 010 addi, 100 R-type funct.
- reg_dst  out  1  destination register: 1=rd, 0=rt.
- mem_to_reg  out  1  writeback source: 1=MDR.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
- mem_timeout  out  1  one-cycle pulse on a memory access abort.
- busy  out  1  high in every state except idle FETCH with run=0.

Behaviour:
- Opcode classes:
  - lw = op[5]&~op[3]
  - sw = op[5]&op[3]
  - branch = ~op[5]&op[2]
  - beq = branch&~op[0]
  - bgtz = branch&op[1]
  - bne = branch & ~beq & ~bgtz
  - addi = ~op[5]&op[3]
  - R-type = op==0
  - Any other opcode is illegal.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH.
- Outputs are Moore, decoded from the state register plus mem_ready. Every output not listed for a state is 0.
- Reset (asynchronous on rst_n low):
  - State goes to FETCH and the timeout counter clears.
  - All outputs are 0, including mem_req; mem_req is gated by run.
  - Reset mid-access simply drops mem_req.
- FETCH:
  - If run=0: hold, no request.
  - If run=1: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - On mem_ready: ir_write=1, pc_write=1, pc_source=0, next state DECODE.
- DECODE:
  - Computes the branch target: alu_src_a=0, alu_src_b=11, alu_op=000.
  - Next state by class: lw/sw→MEM_ADDR, R-type→EXEC_R, addi→EXEC_I, branch→BRANCH.
  - Illegal opcode: pulse illegal_op, go to FETCH. PC has already advanced.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req, mem_read, i_or_d=1. On mem_ready go to WB_MEM.
- WB_MEM: reg_write, mem_to_reg, reg_dst=0. Next state FETCH.
- MEM_WR: mem_req, mem_write, i_or_d=1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=100. Next state WB_R.
- WB_R: reg_write, reg_dst=1. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=010. Next state WB_I.
- WB_I: reg_write, reg_dst=0. Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=1.
  - Exactly one of branch_eq/ne/gtz is high, per class.
  - Next state FETCH.
- Latency with mem_ready asserted the same cycle as the request:
  - R-type 4 cycles, addi 4, lw 5, sw 4, branch 3.
- Memory wait timeout:
  - The counter runs while mem_req=1 and mem_ready=0, and clears on state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: pulse mem_timeout, drop mem_req, go to FETCH.
  - After a fetch abort, PC is not advanced and the same instruction is refetched.
  - After an MEM_RD abort there is no register write.
- mem_ready arriving on the timeout cycle: ready wins, no timeout.
- mem_ready outside MEM_RD/MEM_WR/FETCH-with-request: ignored.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum/localparams
  - opcode constants OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_BGTZ 000111, OP_ADDI 001000
  - ALUOp and alu_src_b encodings
- Sub-module opcode_classifier: combinational, opcode in, one-hot class plus illegal out, reusable by the single-cycle path.

Test Plan:
- Reset with run=1, mem_ready tied 1, opcode 000000 → FETCH, DECODE, EXEC_R, WB_R. reg_write=1 and reg_dst=1 in cycle 4 only; alu_op=100 in cycle 3.
- lw (100011) with mem_ready delayed 2 cycles in MEM_RD → 7-cycle instruction. mem_req held 3 cycles with i_or_d=1; WB_MEM has mem_to_reg=1.
- bne (000101) → 3 cycles; BRANCH has branch_ne=1, branch_eq=0, branch_gtz=0, alu_op=001, pc_source=1. Repeat for beq (000100) and bgtz (000111).
- Opcode 111111 → illegal_op pulse in DECODE, next state FETCH, reg_write never asserted.
- sw with mem_ready held 0, MEM_TIMEOUT=12 → mem_write high 12 cycles, then mem_timeout pulse, FETCH. Also: mem_ready on the 12th cycle → no timeout.
- Assert rst_n low mid-MEM_WR → mem_req/mem_write drop immediately, state FETCH. With run=0 after release: busy=0, no request.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: states, opcodes,
// ALU and operand-select encodings, and the decoded opcode class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_ADDI  = 3'b010,
    ALU_RTYPE = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic bgtz;
    logic addi;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int unsigned OPCODE_W = 6
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                pc_write;
  logic                branch_eq;
  logic                branch_ne;
  logic                branch_gtz;
  logic                pc_source;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_op;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                illegal_op;
  logic                mem_timeout;
  logic                busy;

  modport master (
    input  run, opcode, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
           branch_eq, branch_ne, branch_gtz, pc_source, alu_src_a,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal_op, mem_timeout, busy
  );

  modport slave (
    output run, opcode, mem_ready,
    input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
           branch_eq, branch_ne, branch_gtz, pc_source, alu_src_a,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal_op, mem_timeout, busy
  );
endinterface

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// Combinational opcode decode into a one-hot instruction class plus illegal flag;
// shared with the single-cycle control path.
module opcode_classifier
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_t           class_o,
  output logic                illegal_o
);

  // Full-opcode match: the bit-level class equations alias unlisted opcodes
  // (e.g. 111111 would look like sw), which must decode as illegal instead.
  always_comb begin
    class_o       = '0;
    class_o.rtype = (opcode_i == OPCODE_W'(OP_RTYPE));
    class_o.lw    = (opcode_i == OPCODE_W'(OP_LW));
    class_o.sw    = (opcode_i == OPCODE_W'(OP_SW));
    class_o.beq   = (opcode_i == OPCODE_W'(OP_BEQ));
    class_o.bne   = (opcode_i == OPCODE_W'(OP_BNE));
    class_o.bgtz  = (opcode_i == OPCODE_W'(OP_BGTZ));
    class_o.addi  = (opcode_i == OPCODE_W'(OP_ADDI));
    illegal_o     = ~|class_o;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through the shared
// ALU / unified memory datapath, with a bounded wait on every memory access.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned TIMEOUT_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 12
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e                state_q;
  logic [TIMEOUT_W-1:0]  cnt_q;
  op_class_t             cls;
  logic                  illegal;
  logic                  fetch_req;
  logic                  mem_phase;
  logic                  ready_hit;
  logic                  expire;

  opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
    .opcode_i  (bus.opcode),
    .class_o   (cls),
    .illegal_o (illegal)
  );

  // A nonzero wait count means a fetch request is already outstanding, so it
  // stays up even if run drops mid-wait.
  always_comb begin
    fetch_req = (state_q == S_FETCH) && (bus.run || (cnt_q != '0));
    mem_phase = fetch_req || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    ready_hit = mem_phase && bus.mem_ready;
    expire    = mem_phase && !bus.mem_ready && (cnt_q == TIMEOUT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      cnt_q <= (mem_phase && !bus.mem_ready && !expire) ? cnt_q + 1'b1 : '0;
      unique case (state_q)
        S_FETCH:    if (ready_hit) state_q <= S_DECODE;
        S_DECODE: begin
          if (cls.lw || cls.sw)                    state_q <= S_MEM_ADDR;
          else if (cls.rtype)                      state_q <= S_EXEC_R;
          else if (cls.addi)                       state_q <= S_EXEC_I;
          else if (cls.beq || cls.bne || cls.bgtz) state_q <= S_BRANCH;
          else                                     state_q <= S_FETCH;
        end
        S_MEM_ADDR: state_q <= cls.lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (ready_hit)   state_q <= S_WB_MEM;
          else if (expire) state_q <= S_FETCH;
        end
        S_MEM_WR:   if (ready_hit || expire) state_q <= S_FETCH;
        S_EXEC_R:   state_q <= S_WB_R;
        S_EXEC_I:   state_q <= S_WB_I;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is held, including the run-gated fetch request.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.i_or_d      = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.branch_eq   = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.branch_gtz  = 1'b0;
    bus.pc_source   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_RT;
    bus.alu_op      = ALU_ADD;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    bus.busy        = 1'b0;
    if (rst_n) begin
      bus.busy = (state_q != S_FETCH) || fetch_req;
      unique case (state_q)
        S_FETCH: if (fetch_req) begin
          bus.mem_req     = 1'b1;
          bus.mem_read    = 1'b1;
          bus.alu_src_b   = SRCB_FOUR;
          bus.ir_write    = ready_hit;
          bus.pc_write    = ready_hit;
          bus.mem_timeout = expire;
        end
        S_DECODE: begin
          bus.alu_src_b  = SRCB_IMM_SH2;
          bus.illegal_op = illegal;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          bus.mem_req     = 1'b1;
          bus.mem_read    = 1'b1;
          bus.i_or_d      = 1'b1;
          bus.mem_timeout = expire;
        end
        S_MEM_WR: begin
          bus.mem_req     = 1'b1;
          bus.mem_write   = 1'b1;
          bus.i_or_d      = 1'b1;
          bus.mem_timeout = expire;
        end
        S_WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_RTYPE;
        end
        S_WB_R: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.alu_op    = ALU_ADDI;
        end
        S_WB_I:   bus.reg_write = 1'b1;
        S_BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = ALU_SUB;
          bus.pc_source  = 1'b1;
          bus.branch_eq  = cls.beq;
          bus.branch_ne  = cls.bne;
          bus.branch_gtz = cls.bgtz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each scenario queues per-cycle
// stimulus with the expected control word, then drains the queue cycle by cycle.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic       branch_eq, branch_ne, branch_gtz, pc_source, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout, busy;
  } out_t;

  typedef struct packed {
    logic       run;
    logic       rdy;
    logic [5:0] op;
    out_t       exp;
  } step_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_cmp = 0;
  int    n_err = 0;
  step_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.OPCODE_W(6)) bus ();

  multicycle_control_fsm #(.OPCODE_W(6), .TIMEOUT_W(4), .MEM_TIMEOUT(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic out_t snap();
    out_t o;
    o = '{bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
          bus.pc_write, bus.branch_eq, bus.branch_ne, bus.branch_gtz,
          bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_dst,
          bus.mem_to_reg, bus.reg_write, bus.illegal_op, bus.mem_timeout, bus.busy};
    return o;
  endfunction

  // Expected control words for each state, written from the state table.
  function automatic out_t e_fetch(input logic rdy, input logic to);
    out_t o = '0;
    o.mem_req = 1; o.mem_read = 1; o.alu_src_b = 2'b01; o.busy = 1;
    o.ir_write = rdy; o.pc_write = rdy; o.mem_timeout = to;
    return o;
  endfunction
  function automatic out_t e_decode(input logic ill);
    out_t o = '0;
    o.alu_src_b = 2'b11; o.illegal_op = ill; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_memaddr();
    out_t o = '0;
    o.alu_src_a = 1; o.alu_src_b = 2'b10; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_memrd(input logic to);
    out_t o = '0;
    o.mem_req = 1; o.mem_read = 1; o.i_or_d = 1; o.mem_timeout = to; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_memwr(input logic to);
    out_t o = '0;
    o.mem_req = 1; o.mem_write = 1; o.i_or_d = 1; o.mem_timeout = to; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_wbmem();
    out_t o = '0;
    o.reg_write = 1; o.mem_to_reg = 1; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_execr();
    out_t o = '0;
    o.alu_src_a = 1; o.alu_op = 3'b100; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_wbr();
    out_t o = '0;
    o.reg_write = 1; o.reg_dst = 1; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_execi();
    out_t o = '0;
    o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_wbi();
    out_t o = '0;
    o.reg_write = 1; o.busy = 1;
    return o;
  endfunction
  function automatic out_t e_branch(input logic eq, input logic ne, input logic gtz);
    out_t o = '0;
    o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_source = 1; o.busy = 1;
    o.branch_eq = eq; o.branch_ne = ne; o.branch_gtz = gtz;
    return o;
  endfunction

  task automatic push(input logic run, input logic rdy, input logic [5:0] op, input out_t e);
    sb.push_back('{run, rdy, op, e});
  endtask

  task automatic test_reset();
    out_t obs;
    rst_n = 0; bus.run = 1; bus.mem_ready = 1; bus.opcode = OP_RTYPE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_outputs got %h exp %h", obs, out_t'('0)); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_rtype();
    step_t st; out_t obs; int cyc = 0;
    push(1, 1, OP_RTYPE, e_fetch(1, 0));
    push(1, 1, OP_RTYPE, e_decode(0));
    push(1, 1, OP_RTYPE, e_execr());
    push(1, 1, OP_RTYPE, e_wbr());
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL rtype cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    step_t st; out_t obs; int cyc = 0;
    push(1, 1, OP_LW, e_fetch(1, 0));
    push(1, 1, OP_LW, e_decode(0));
    push(1, 1, OP_LW, e_memaddr());
    push(1, 0, OP_LW, e_memrd(0));
    push(1, 0, OP_LW, e_memrd(0));
    push(1, 1, OP_LW, e_memrd(0));
    push(1, 0, OP_LW, e_wbmem());
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL lw cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branches();
    step_t st; out_t obs; int cyc = 0;
    logic [5:0] ops [3];
    ops[0] = OP_BNE; ops[1] = OP_BEQ; ops[2] = OP_BGTZ;
    for (int i = 0; i < 3; i++) begin
      push(1, 1, ops[i], e_fetch(1, 0));
      push(1, 1, ops[i], e_decode(0));
      push(1, 1, ops[i], e_branch(ops[i] == OP_BEQ, ops[i] == OP_BNE, ops[i] == OP_BGTZ));
    end
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL branch op%b cyc%0d got %h exp %h", st.op, cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t st; out_t obs; int cyc = 0;
    for (int i = 0; i < 2; i++) begin
      push(1, 1, 6'b111111, e_fetch(1, 0));
      push(1, 1, 6'b111111, e_decode(1));
    end
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL illegal cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_timeout();
    step_t st; out_t obs; int cyc = 0;
    for (int k = 0; k < 2; k++) begin
      push(1, 1, OP_SW, e_fetch(1, 0));
      push(1, 1, OP_SW, e_decode(0));
      push(1, 1, OP_SW, e_memaddr());
      for (int i = 0; i < 11; i++) push(1, 0, OP_SW, e_memwr(0));
      // first pass: no ready by the 12th wait cycle; second: ready arrives on it
      if (k == 0) push(1, 0, OP_SW, e_memwr(1));
      else        push(1, 1, OP_SW, e_memwr(0));
    end
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL sw_timeout cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_timeout();
    step_t st; out_t obs; int cyc = 0;
    push(1, 0, OP_RTYPE, e_fetch(0, 0));
    for (int i = 0; i < 10; i++) push(0, 0, OP_RTYPE, e_fetch(0, 0));
    push(0, 0, OP_RTYPE, e_fetch(0, 1));
    push(1, 1, OP_RTYPE, e_fetch(1, 0));
    push(1, 1, OP_RTYPE, e_decode(0));
    push(1, 1, OP_RTYPE, e_execr());
    push(1, 1, OP_RTYPE, e_wbr());
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL fetch_timeout cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t st; out_t obs; int cyc = 0;
    push(1, 1, OP_ADDI, e_fetch(1, 0));
    push(1, 1, OP_ADDI, e_decode(0));
    push(1, 1, OP_ADDI, e_execi());
    push(1, 1, OP_ADDI, e_wbi());
    push(1, 1, OP_SW, e_fetch(1, 0));
    push(1, 1, OP_SW, e_decode(0));
    push(1, 1, OP_SW, e_memaddr());
    push(1, 1, OP_SW, e_memwr(0));
    push(1, 1, OP_BEQ, e_fetch(1, 0));
    push(1, 1, OP_BEQ, e_decode(0));
    push(1, 1, OP_BEQ, e_branch(1, 0, 0));
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL back_to_back cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wr();
    step_t st; out_t obs; int cyc = 0;
    push(1, 1, OP_SW, e_fetch(1, 0));
    push(1, 1, OP_SW, e_decode(0));
    push(1, 1, OP_SW, e_memaddr());
    push(1, 0, OP_SW, e_memwr(0));
    push(1, 0, OP_SW, e_memwr(0));
    while (sb.size() > 0) begin
      st = sb.pop_front();
      bus.run = st.run; bus.mem_ready = st.rdy; bus.opcode = st.op;
      @(negedge clk);
      obs = snap();
      n_cmp++;
      if (obs !== st.exp) begin n_err++; $display("FAIL rst_pre cyc%0d got %h exp %h", cyc, obs, st.exp); end
      cyc++;
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rst_drop got %h exp %h", obs, out_t'('0)); end
    bus.run = 0;
    #1 rst_n = 1;
    @(negedge clk);
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL idle_after_rst got %h exp %h", obs, out_t'('0)); end
    @(posedge clk); #1;
    bus.mem_ready = 1;
    @(negedge clk);
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL idle_ready_ignored got %h exp %h", obs, out_t'('0)); end
    @(posedge clk); #1;
    bus.run = 1;
    @(negedge clk);
    obs = snap();
    n_cmp++;
    if (obs !== e_fetch(1, 0)) begin n_err++; $display("FAIL fetch_after_rst got %h exp %h", obs, e_fetch(1, 0)); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branches();
    test_illegal();
    test_sw_timeout();
    test_fetch_timeout();
    test_back_to_back();
    test_reset_mid_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
